// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch run-control sequencer.
// The stall-counter width helper keeps the counter at least one bit wide.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STALL,
        DONE
    } seq_state_t;

    localparam int CNT_W_DEF        = 16;
    localparam int STALL_CYCLES_DEF = 2;
    localparam int STALL_W_DEF      = $clog2(STALL_CYCLES_DEF + 1);

    function automatic int stall_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Run-control sequencer: turns the Start/Done handshake and decode flags into
// the Init/Halt/Branch controls of the PC register, with memory stalls and a watchdog.
//
// state | meaning
// IDLE  | waiting for Start, PC held
// LOAD  | one-cycle PC clear, counters and Timeout cleared
// RUN   | executing one instruction per cycle
// STALL | holding the PC on a memory instruction
// DONE  | finished (halt or watchdog), waiting for Start to drop
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int STALL_CYCLES = 2,
    parameter int MAX_CYCLES   = 1000,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             Init,
    input  logic             Start,
    input  logic             IsHalt,
    input  logic             IsMem,
    input  logic             IsBranch,
    input  logic             CondFlag,
    output logic             FetchInit,
    output logic             Halt,
    output logic             Branch,
    output logic             Done,
    output logic             Timeout,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W-1:0] BranchCount
);

    localparam int               STALL_W    = stall_w(STALL_CYCLES);
    localparam logic             MEM_STALLS = (STALL_CYCLES > 0);
    localparam logic [STALL_W-1:0] STALL_LOAD =
        (STALL_CYCLES > 0) ? STALL_W'(STALL_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    seq_state_t         r_state;
    logic [STALL_W-1:0] r_stall;
    logic               r_fetch_init;
    logic               r_done;
    logic               r_timeout;

    logic               w_halt;
    logic               w_branch;
    logic               w_mem_stall;
    logic               w_last;
    logic               w_cnt_clr;
    logic               w_cyc_en;

    assign w_mem_stall = IsMem && MEM_STALLS;
    // The cycle entered at MAX_CYCLES-1 is the final executed cycle of the run.
    assign w_last      = ((r_state == RUN) || (r_state == STALL)) && (CycleCount == LAST_CYCLE);

    always_ff @(posedge CLK) begin
        if (Init) begin
            r_state      <= IDLE;
            r_stall      <= '0;
            r_fetch_init <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_fetch_init <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_state      <= LOAD;
                        r_fetch_init <= 1'b1;
                    end
                end
                LOAD: begin
                    r_timeout <= 1'b0;
                    r_state   <= RUN;
                end
                RUN: begin
                    if (IsHalt) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else if (w_last) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if (w_mem_stall) begin
                        r_stall <= STALL_LOAD;
                        r_state <= STALL;
                    end
                end
                STALL: begin
                    if (w_last) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if (r_stall != '0) begin
                        r_stall <= r_stall - STALL_W'(1);
                    end else begin
                        r_state <= RUN;
                    end
                end
                DONE: begin
                    if (!Start) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Halt/Branch are Mealy so the fetch unit sees this cycle's decode directly.
    always_comb begin
        w_halt   = 1'b1;
        w_branch = 1'b0;
        case (r_state)
            LOAD: begin
                w_halt = 1'b0;
            end
            RUN: begin
                if (IsHalt || w_mem_stall) begin
                    w_halt = 1'b1;
                end else begin
                    w_halt   = 1'b0;
                    w_branch = IsBranch && CondFlag;
                end
            end
            STALL: begin
                w_halt = (r_stall != '0);
            end
            default: begin
                w_halt   = 1'b1;
                w_branch = 1'b0;
            end
        endcase
    end

    assign w_cnt_clr = Init || (r_state == LOAD);
    assign w_cyc_en  = (r_state == RUN) || (r_state == STALL);

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .i_clk    (CLK),
        .i_clear  (w_cnt_clr),
        .i_enable (w_cyc_en),
        .o_count  (CycleCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .i_clk    (CLK),
        .i_clear  (w_cnt_clr),
        .i_enable (w_branch),
        .o_count  (BranchCount)
    );

    assign FetchInit = r_fetch_init;
    assign Halt      = w_halt;
    assign Branch    = w_branch;
    assign Done      = r_done;
    assign Timeout   = r_timeout;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a PC-register model plus small programs, with the
// expected per-cycle PC/Halt/Branch trace queued by an instruction-level walker.
module tb_fetch_sequencer;

    localparam int STALL = 2;
    localparam int MAXC  = 20;
    localparam int CW    = 16;

    logic          CLK = 1'b0;
    logic          Init, Start, IsHalt, IsMem, IsBranch, CondFlag;
    logic          FetchInit, Halt, Branch, Done, Timeout;
    logic [CW-1:0] CycleCount, BranchCount;

    fetch_sequencer #(
        .STALL_CYCLES (STALL),
        .MAX_CYCLES   (MAXC),
        .CNT_W        (CW)
    ) dut (
        .CLK         (CLK),
        .Init        (Init),
        .Start       (Start),
        .IsHalt      (IsHalt),
        .IsMem       (IsMem),
        .IsBranch    (IsBranch),
        .CondFlag    (CondFlag),
        .FetchInit   (FetchInit),
        .Halt        (Halt),
        .Branch      (Branch),
        .Done        (Done),
        .Timeout     (Timeout),
        .CycleCount  (CycleCount),
        .BranchCount (BranchCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] halt_mask;
        logic [31:0] mem_mask;
        int          br_pc;
        int          br_off;
        logic        cond;
        logic        drop_start;
        int          exp_cycles;
        int          exp_br;
        int          exp_to;
    } vec_t;

    typedef struct {
        int   pc;
        logic halt;
        logic br;
    } cyc_t;

    vec_t vecs[10];
    cyc_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pc;
    int   pc_n;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_decode(input vec_t v, input int p);
        IsHalt   = (p >= 0 && p < 32) ? v.halt_mask[p] : 1'b0;
        IsMem    = (p >= 0 && p < 32) ? v.mem_mask[p] : 1'b0;
        IsBranch = (p == v.br_pc);
        CondFlag = v.cond;
    endtask

    task automatic clear_decode();
        IsHalt = 0; IsMem = 0; IsBranch = 0; CondFlag = 0;
    endtask

    // Instruction-level reference: memory ops occupy 1+STALL cycles, the run ends at MAXC cycles.
    task automatic build_expected(input vec_t v);
        int   p;
        int   cyc;
        cyc_t e;
        exp_q.delete();
        p   = 0;
        cyc = 0;
        while (cyc < MAXC) begin
            e.pc = p;
            if (v.halt_mask[p]) begin
                e.halt = 1; e.br = 0; exp_q.push_back(e); cyc++;
                break;
            end else if (v.mem_mask[p]) begin
                for (int k = 0; k <= STALL; k++) begin
                    if (cyc < MAXC) begin
                        e.halt = (k < STALL); e.br = 0; exp_q.push_back(e); cyc++;
                    end
                end
                p++;
            end else if (p == v.br_pc && v.cond) begin
                e.halt = 0; e.br = 1; exp_q.push_back(e); cyc++;
                p += v.br_off;
            end else begin
                e.halt = 0; e.br = 0; exp_q.push_back(e); cyc++;
                p++;
            end
        end
    endtask

    task automatic next_pc(input vec_t v);
        if (FetchInit)   pc_n = 0;
        else if (Halt)   pc_n = pc;
        else if (Branch) pc_n = pc + v.br_off;
        else             pc_n = pc + 1;
    endtask

    task automatic run_vec(input vec_t v);
        cyc_t e;
        logic seen_done;
        build_expected(v);
        @(negedge CLK);
        clear_decode();
        Start = 1;
        @(posedge CLK);
        @(negedge CLK);
        check({v.name, " load FetchInit"}, int'(FetchInit), 1);
        check({v.name, " load Halt"}, int'(Halt), 0);
        next_pc(v);
        if (v.drop_start) Start = 0;
        @(posedge CLK);
        pc = pc_n;
        seen_done = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            drive_decode(v, pc);
            #1;
            if (Done) begin
                seen_done = 1;
                break;
            end
            if (exp_q.size() == 0) begin
                e.pc = -1; e.halt = 0; e.br = 0;
            end else begin
                e = exp_q.pop_front();
            end
            check({v.name, " pc/fi/halt/br"},
                  pc * 8 + int'(FetchInit) * 4 + int'(Halt) * 2 + int'(Branch),
                  e.pc * 8 + int'(e.halt) * 2 + int'(e.br));
            next_pc(v);
            @(posedge CLK);
            pc = pc_n;
        end
        if (!seen_done) check({v.name, " done seen"}, int'(Done), 1);
        clear_decode();
        check({v.name, " trace left"}, exp_q.size(), 0);
        check({v.name, " CycleCount"}, int'(CycleCount), v.exp_cycles);
        check({v.name, " BranchCount"}, int'(BranchCount), v.exp_br);
        check({v.name, " Timeout"}, int'(Timeout), v.exp_to);
        check({v.name, " done Halt/Branch"}, int'(Halt) * 2 + int'(Branch), 2);
        if (!v.drop_start) begin
            repeat (3) begin
                @(negedge CLK);
                check({v.name, " hold Done/FetchInit"}, int'(Done) * 2 + int'(FetchInit), 2);
            end
            check({v.name, " hold CycleCount"}, int'(CycleCount), v.exp_cycles);
            Start = 0;
        end
        @(posedge CLK);
        @(negedge CLK);
        check({v.name, " idle Done"}, int'(Done), 0);
        check({v.name, " idle Halt"}, int'(Halt), 1);
        check({v.name, " idle CycleCount"}, int'(CycleCount), v.exp_cycles);
        check({v.name, " idle Timeout"}, int'(Timeout), v.exp_to);
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit: got timeout expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        //             name          halt      mem       brpc off cond drop cyc br to
        vecs[0] = '{"straight",  32'h20,   32'h0,    -1,  0, 0, 0, 6,  0, 0};
        vecs[1] = '{"mem_pc1",   32'h8,    32'h2,    -1,  0, 0, 0, 6,  0, 0};
        vecs[2] = '{"br_nt",     32'h28,   32'h0,     2,  3, 0, 0, 4,  0, 0};
        vecs[3] = '{"br_t",      32'h28,   32'h0,     2,  3, 1, 0, 4,  1, 0};
        vecs[4] = '{"loop_wd",   32'h0,    32'h0,     3, -1, 1, 0, 20, 9, 1};
        vecs[5] = '{"halt0_drop",32'h1,    32'h0,    -1,  0, 0, 1, 1,  0, 0};
        vecs[6] = '{"halt_last", 32'h80000,32'h0,    -1,  0, 0, 0, 20, 0, 0};
        vecs[7] = '{"straight_wd",32'h2000000,32'h0, -1,  0, 0, 0, 20, 0, 1};
        vecs[8] = '{"mem_last",  32'h2000000,32'h80000,-1, 0, 0, 0, 20, 0, 1};
        vecs[9] = '{"mem_pc0",   32'h2,    32'h1,    -1,  0, 0, 0, 4,  0, 0};

        Init = 1; Start = 1;
        clear_decode();
        pc = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset Halt", int'(Halt), 1);
        check("reset Branch", int'(Branch), 0);
        check("reset FetchInit", int'(FetchInit), 0);
        check("reset Done/Timeout", int'(Done) * 2 + int'(Timeout), 0);
        check("reset CycleCount", int'(CycleCount), 0);
        check("reset BranchCount", int'(BranchCount), 0);
        Init = 0; Start = 0;
        @(posedge CLK);
        @(negedge CLK);
        check("idle after reset Halt/FetchInit", int'(Halt) * 2 + int'(FetchInit), 2);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Init while a memory instruction is stalling.
        @(negedge CLK);
        clear_decode();
        Start = 1;
        @(posedge CLK);              // -> LOAD
        @(negedge CLK);
        Start = 0;
        @(posedge CLK);              // -> RUN pc0
        @(negedge CLK);
        clear_decode();
        @(posedge CLK);              // -> RUN pc1
        @(negedge CLK);
        IsMem = 1;
        #1;
        check("mem issue Halt", int'(Halt), 1);
        @(posedge CLK);              // -> STALL
        @(negedge CLK);
        IsMem = 0;
        #1;
        check("stall Halt", int'(Halt), 1);
        check("stall CycleCount", int'(CycleCount), 2);
        Init = 1;
        @(posedge CLK);
        @(negedge CLK);
        Init = 0;
        check("init-in-stall Halt", int'(Halt), 1);
        check("init-in-stall Done", int'(Done), 0);
        check("init-in-stall CycleCount", int'(CycleCount), 0);
        check("init-in-stall FetchInit", int'(FetchInit), 0);
        @(posedge CLK);
        @(negedge CLK);
        check("idle after init Halt/FetchInit", int'(Halt) * 2 + int'(FetchInit), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
